// File: rtl/util_rom_dp_arb.sv
// ============================================================================
// util_rom_dp_arb : round-robin arbiter sharing a dual-port ROM among NUM_REQ
// requesters. Define UTIL_ROM_DP_ARB_FIXED_PRIO_EN for fixed priority.
// Revision: 1.0
// ============================================================================
`default_nettype none

module util_rom_dp_arb #(
    parameter int NUM_REQ       = 4,
    parameter int ROM_WIDTH     = 32,
    parameter int ROM_ADDR_BITS = 12
) (
    input  logic                               clk,
    input  logic                               rstn,
    input  logic [NUM_REQ-1:0]                 req_valid,
    input  logic [NUM_REQ*ROM_ADDR_BITS-1:0]   req_addr,
    output logic [NUM_REQ-1:0]                 req_ready,
    output logic [NUM_REQ-1:0]                 resp_valid,
    output logic [NUM_REQ*ROM_WIDTH-1:0]       resp_data,
    output logic [ROM_ADDR_BITS-1:0]           rom_addra,
    input  logic [ROM_WIDTH-1:0]               rom_dataa,
    output logic [ROM_ADDR_BITS-1:0]           rom_addrb,
    input  logic [ROM_WIDTH-1:0]               rom_datab
);

    localparam int IDW = $clog2(NUM_REQ);

    logic               gnt_a_vld, gnt_b_vld;
    logic [IDW-1:0]     gnt_a_id, gnt_b_id;
    int                 start_i;
    int                 cand;

    logic               tag_a_vld_q, tag_a_vld_d;
    logic               tag_b_vld_q, tag_b_vld_d;
    logic [IDW-1:0]     tag_a_id_q, tag_a_id_d;
    logic [IDW-1:0]     tag_b_id_q, tag_b_id_d;
    logic [NUM_REQ-1:0]           resp_valid_q, resp_valid_d;
    logic [NUM_REQ*ROM_WIDTH-1:0] resp_data_q, resp_data_d;

`ifdef UTIL_ROM_DP_ARB_FIXED_PRIO_EN
    always_comb start_i = 0;
`else
    logic [IDW-1:0]     rr_ptr_q, rr_ptr_d;
    logic [IDW-1:0]     last_id;

    always_comb start_i = int'(rr_ptr_q);

    // Pointer moves past the last requester served; holds on idle cycles.
    always_comb begin
        last_id  = gnt_b_vld ? gnt_b_id : gnt_a_id;
        rr_ptr_d = rr_ptr_q;
        if (gnt_a_vld) begin
            rr_ptr_d = IDW'((int'(last_id) + 1) % NUM_REQ);
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            rr_ptr_q <= '0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
        end
    end
`endif

    // First valid requester from the start point gets port A, second gets port B.
    always_comb begin
        gnt_a_vld = 1'b0;
        gnt_b_vld = 1'b0;
        gnt_a_id  = '0;
        gnt_b_id  = '0;
        cand      = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = (start_i + k) % NUM_REQ;
            for (int j = 0; j < NUM_REQ; j++) begin
                if (rstn && req_valid[j] && (j == cand)) begin
                    if (!gnt_a_vld) begin
                        gnt_a_vld = 1'b1;
                        gnt_a_id  = IDW'(j);
                    end else if (!gnt_b_vld) begin
                        gnt_b_vld = 1'b1;
                        gnt_b_id  = IDW'(j);
                    end
                end
            end
        end
    end

    always_comb begin
        req_ready = '0;
        rom_addra = '0;
        rom_addrb = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt_a_vld && (gnt_a_id == IDW'(i))) begin
                req_ready[i] = 1'b1;
                rom_addra    = req_addr[i*ROM_ADDR_BITS +: ROM_ADDR_BITS];
            end
            if (gnt_b_vld && (gnt_b_id == IDW'(i))) begin
                req_ready[i] = 1'b1;
                rom_addrb    = req_addr[i*ROM_ADDR_BITS +: ROM_ADDR_BITS];
            end
        end
    end

    always_comb begin
        tag_a_vld_d = gnt_a_vld;
        tag_a_id_d  = gnt_a_id;
        tag_b_vld_d = gnt_b_vld;
        tag_b_id_d  = gnt_b_id;
    end

    // Tags line up with the ROM output, steering each port's data to its owner.
    always_comb begin
        resp_valid_d = '0;
        resp_data_d  = resp_data_q;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (tag_a_vld_q && (tag_a_id_q == IDW'(i))) begin
                resp_valid_d[i]                    = 1'b1;
                resp_data_d[i*ROM_WIDTH +: ROM_WIDTH] = rom_dataa;
            end else if (tag_b_vld_q && (tag_b_id_q == IDW'(i))) begin
                resp_valid_d[i]                    = 1'b1;
                resp_data_d[i*ROM_WIDTH +: ROM_WIDTH] = rom_datab;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            tag_a_vld_q  <= 1'b0;
            tag_b_vld_q  <= 1'b0;
            tag_a_id_q   <= '0;
            tag_b_id_q   <= '0;
            resp_valid_q <= '0;
            resp_data_q  <= '0;
        end else begin
            tag_a_vld_q  <= tag_a_vld_d;
            tag_b_vld_q  <= tag_b_vld_d;
            tag_a_id_q   <= tag_a_id_d;
            tag_b_id_q   <= tag_b_id_d;
            resp_valid_q <= resp_valid_d;
            resp_data_q  <= resp_data_d;
        end
    end

    assign resp_valid = resp_valid_q;
    assign resp_data  = resp_data_q;

endmodule

`default_nettype wire

// File: tb/tb_util_rom_dp_arb.sv
// ============================================================================
// tb_util_rom_dp_arb : scoreboard bench for util_rom_dp_arb with a ROM model.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_util_rom_dp_arb;

    localparam int N  = 4;
    localparam int W  = 32;
    localparam int AW = 12;

    logic              clk = 1'b0;
    logic              rstn;
    logic [N-1:0]      req_valid;
    logic [N*AW-1:0]   req_addr;
    logic [N-1:0]      req_ready;
    logic [N-1:0]      resp_valid;
    logic [N*W-1:0]    resp_data;
    logic [AW-1:0]     rom_addra, rom_addrb;
    logic [W-1:0]      rom_dataa, rom_datab;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int resp_cnt [N];

    typedef struct {
        int           id;
        int           due;
        logic [W-1:0] data;
    } exp_t;
    exp_t sb[$];

    util_rom_dp_arb #(.NUM_REQ(N), .ROM_WIDTH(W), .ROM_ADDR_BITS(AW)) dut (
        .clk        (clk),
        .rstn       (rstn),
        .req_valid  (req_valid),
        .req_addr   (req_addr),
        .req_ready  (req_ready),
        .resp_valid (resp_valid),
        .resp_data  (resp_data),
        .rom_addra  (rom_addra),
        .rom_dataa  (rom_dataa),
        .rom_addrb  (rom_addrb),
        .rom_datab  (rom_datab)
    );

    always #5 clk = ~clk;

    function automatic logic [W-1:0] rom_val(input logic [AW-1:0] a);
        return {4'hC, a, ~a, 4'h3};
    endfunction

    always @(posedge clk) begin
        rom_dataa <= rom_val(rom_addra);
        rom_datab <= rom_val(rom_addrb);
        cyc       <= cyc + 1;
    end

    // Scoreboard: match responses against handshakes recorded two cycles earlier.
    always @(negedge clk) begin
        int idx;
        if (!rstn) begin
            sb.delete();
        end else begin
            for (int i = 0; i < N; i++) begin
                if (resp_valid[i]) begin
                    idx = -1;
                    for (int k = 0; k < sb.size(); k++)
                        if (idx < 0 && sb[k].id == i) idx = k;
                    checks++;
                    if (idx < 0) begin
                        errors++;
                        $display("FAIL resp_unexpected req%0d cycle %0d got data %h expected no response",
                                 i, cyc, resp_data[i*W +: W]);
                    end else begin
                        if (sb[idx].due != cyc || resp_data[i*W +: W] !== sb[idx].data) begin
                            errors++;
                            $display("FAIL resp_data req%0d cycle %0d got %h expected %h at cycle %0d",
                                     i, cyc, resp_data[i*W +: W], sb[idx].data, sb[idx].due);
                        end
                        sb.delete(idx);
                        resp_cnt[i]++;
                    end
                end
            end
            for (int k = sb.size() - 1; k >= 0; k--) begin
                if (sb[k].due <= cyc) begin
                    checks++;
                    errors++;
                    $display("FAIL resp_missing req%0d cycle %0d got no response expected %h",
                             sb[k].id, cyc, sb[k].data);
                    sb.delete(k);
                end
            end
            for (int i = 0; i < N; i++) begin
                if (req_valid[i] && req_ready[i])
                    sb.push_back('{id: i, due: cyc + 2, data: rom_val(req_addr[i*AW +: AW])});
            end
        end
    end

    task automatic next_cycle;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rstn      = 1'b0;
        req_valid = '0;
        repeat (2) next_cycle();
        rstn = 1'b1;
    endtask

    task automatic set_addr(input int i, input logic [AW-1:0] a);
        req_addr[i*AW +: AW] = a;
    endtask

    task automatic test_reset;
        rstn      = 1'b0;
        req_valid = '1;
        req_addr  = {12'h003, 12'h002, 12'h001, 12'h007};
        next_cycle();
        @(negedge clk);
        checks++;
        if (req_ready !== '0 || rom_addra !== '0 || rom_addrb !== '0) begin
            errors++;
            $display("FAIL reset_grant got ready %b addra %h addrb %h expected 0000 000 000",
                     req_ready, rom_addra, rom_addrb);
        end
        checks++;
        if (resp_valid !== '0 || resp_data !== '0) begin
            errors++;
            $display("FAIL reset_resp got valid %b data %h expected all zero", resp_valid, resp_data);
        end
        next_cycle();
        req_valid = '0;
        rstn      = 1'b1;
        next_cycle();
    endtask

    task automatic test_single;
        req_valid = 4'b0001;
        set_addr(0, 12'h005);
        @(negedge clk);
        checks++;
        if (req_ready !== 4'b0001 || rom_addra !== 12'h005 || rom_addrb !== 12'h000) begin
            errors++;
            $display("FAIL single_grant got ready %b addra %h addrb %h expected 0001 005 000",
                     req_ready, rom_addra, rom_addrb);
        end
        next_cycle();
        req_valid = '0;
        @(negedge clk);
        checks++;
        if (resp_valid !== '0) begin
            errors++;
            $display("FAIL single_early got resp_valid %b expected 0000", resp_valid);
        end
        @(negedge clk);
        checks++;
        if (resp_valid !== 4'b0001 || resp_data[0 +: W] !== rom_val(12'h005)) begin
            errors++;
            $display("FAIL single_resp got valid %b data %h expected 0001 %h",
                     resp_valid, resp_data[0 +: W], rom_val(12'h005));
        end
        next_cycle();
    endtask

    task automatic test_two_same_cycle;
        do_reset();
        req_valid = 4'b0110;
        set_addr(1, 12'h011);
        set_addr(2, 12'h022);
        @(negedge clk);
        checks++;
        if (req_ready !== 4'b0110 || rom_addra !== 12'h011 || rom_addrb !== 12'h022) begin
            errors++;
            $display("FAIL two_grant got ready %b addra %h addrb %h expected 0110 011 022",
                     req_ready, rom_addra, rom_addrb);
        end
        next_cycle();
        req_valid = '0;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (resp_valid !== 4'b0110) begin
            errors++;
            $display("FAIL two_resp got valid %b expected 0110", resp_valid);
        end
        next_cycle();
    endtask

`ifndef UTIL_ROM_DP_ARB_FIXED_PRIO_EN
    // Runs right after test_two_same_cycle, which leaves the pointer at 3.
    task automatic test_wrap;
        req_valid = 4'b1001;
        set_addr(3, 12'h033);
        set_addr(0, 12'h0A0);
        @(negedge clk);
        checks++;
        if (req_ready !== 4'b1001 || rom_addra !== 12'h033 || rom_addrb !== 12'h0A0) begin
            errors++;
            $display("FAIL wrap_grant got ready %b addra %h addrb %h expected 1001 033 0a0",
                     req_ready, rom_addra, rom_addrb);
        end
        next_cycle();
        req_valid = 4'b0111;
        @(negedge clk);
        checks++;
        if (req_ready !== 4'b0110 || rom_addra !== 12'h011 || rom_addrb !== 12'h022) begin
            errors++;
            $display("FAIL wrap_ptr got ready %b addra %h addrb %h expected 0110 011 022",
                     req_ready, rom_addra, rom_addrb);
        end
        next_cycle();
        req_valid = '0;
        repeat (3) next_cycle();
    endtask

    task automatic test_back_to_back;
        logic [N-1:0]  exp_rdy [4] = '{4'b0011, 4'b1100, 4'b0011, 4'b1100};
        logic [AW-1:0] exp_a   [4] = '{12'h100, 12'h102, 12'h100, 12'h102};
        logic [AW-1:0] exp_b   [4] = '{12'h101, 12'h103, 12'h101, 12'h103};
        int            base    [N];
        do_reset();
        for (int i = 0; i < N; i++) begin
            set_addr(i, AW'(12'h100 + i));
            base[i] = resp_cnt[i];
        end
        req_valid = '1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            checks++;
            if (req_ready !== exp_rdy[c] || rom_addra !== exp_a[c] || rom_addrb !== exp_b[c]) begin
                errors++;
                $display("FAIL b2b_grant cycle %0d got ready %b addra %h addrb %h expected %b %h %h",
                         c, req_ready, rom_addra, rom_addrb, exp_rdy[c], exp_a[c], exp_b[c]);
            end
            next_cycle();
        end
        req_valid = '0;
        repeat (3) next_cycle();
        for (int i = 0; i < N; i++) begin
            checks++;
            if (resp_cnt[i] - base[i] != 2) begin
                errors++;
                $display("FAIL b2b_count req%0d got %0d responses expected 2", i, resp_cnt[i] - base[i]);
            end
        end
    endtask
`else
    task automatic test_fixed_prio;
        do_reset();
        for (int i = 0; i < N; i++) set_addr(i, AW'(12'h200 + i));
        req_valid = '1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            checks++;
            if (req_ready !== 4'b0011 || rom_addra !== 12'h200 || rom_addrb !== 12'h201) begin
                errors++;
                $display("FAIL fixed_grant cycle %0d got ready %b addra %h addrb %h expected 0011 200 201",
                         c, req_ready, rom_addra, rom_addrb);
            end
            next_cycle();
        end
        req_valid = '0;
        repeat (3) next_cycle();
    endtask
`endif

    task automatic test_reset_mid;
        req_valid = 4'b0001;
        set_addr(0, 12'h055);
        @(negedge clk);
        checks++;
        if (req_ready !== 4'b0001) begin
            errors++;
            $display("FAIL midrst_grant got ready %b expected 0001", req_ready);
        end
        next_cycle();
        req_valid = '0;
        rstn      = 1'b0;
        next_cycle();
        rstn = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            checks++;
            if (resp_valid !== '0 || resp_data !== '0) begin
                errors++;
                $display("FAIL midrst_resp cycle %0d got valid %b data %h expected all zero",
                         c, resp_valid, resp_data);
            end
        end
        next_cycle();
    endtask

    initial begin
        rstn      = 1'b0;
        req_valid = '0;
        req_addr  = '0;
        for (int i = 0; i < N; i++) resp_cnt[i] = 0;
        next_cycle();
        test_reset();
        test_single();
        test_two_same_cycle();
`ifndef UTIL_ROM_DP_ARB_FIXED_PRIO_EN
        test_wrap();
        test_back_to_back();
`else
        test_fixed_prio();
`endif
        test_reset_mid();
        repeat (3) next_cycle();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain got %0d outstanding responses expected 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
